// File: rtl/xprog_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths
// and the fetch state encoding.
`ifndef XPROG_FETCH_PKG_SV
`define XPROG_FETCH_PKG_SV

package xprog_fetch_pkg;

    // Default widths.
    localparam int FETCH_ADDR_W_DEF  = 8;
    localparam int FETCH_INSTR_W_DEF = 16;
    localparam int FETCH_CNT_W_DEF   = 16;

    // The program ROM always returns data one cycle after the address.
    // The sequencer is built around that fixed latency.
    localparam int FETCH_ROM_LATENCY = 1;

    // Sequencer state.
    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage

`endif

// File: rtl/xprog_fetch_if.sv
// Fetch-side bus: the ROM address/data pair and the decode handshake.
// master = fetch sequencer, slave = ROM plus decode stage.
interface xprog_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    // ROM port
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_instr;

    // Decode handshake
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               halt;
    logic               stall;

    modport master (
        output rom_addr,
        input  rom_instr,
        output instr,
        output instr_pc,
        output instr_valid,
        input  halt,
        input  stall
    );

    modport slave (
        input  rom_addr,
        output rom_instr,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output halt,
        output stall
    );
endinterface

// File: rtl/xprog_fetch_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment. Holds at all-ones instead of wrapping.
module xprog_fetch_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = &cnt_q;

    // Next count: clear, else increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/xprog_fetch.sv
// Instruction-fetch sequencer for the 1-cycle-latency program ROM.
// Owns the program counter, issues a ROM address every cycle, tracks
// which address the ROM output belongs to and presents a squashable,
// stallable instruction stream to decode. Counts retired instructions.
module xprog_fetch
    import xprog_fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W_DEF,
    parameter int INSTR_W = FETCH_INSTR_W_DEF,
    parameter int CNT_W   = FETCH_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_cnt,
    xprog_fetch_if.master     fbus
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] fpc_q;      // address issued last cycle
    logic              fvalid_q;   // last issue was a real fetch
    logic [ADDR_W-1:0] next_addr;  // address issued this cycle
    logic              in_run;
    logic              valid_w;
    logic              accept;
    logic              launch;     // IDLE -> RUN this edge
    logic              retire_halt;// accepted HALT ends the run

    assign in_run      = (state_q == FETCH_RUN);
    // A branch from execute squashes the word currently in front of decode.
    assign valid_w     = in_run & fvalid_q & ~branch_en;
    assign accept      = valid_w & ~fbus.stall;
    assign launch      = ~in_run & start;
    assign retire_halt = accept & fbus.halt;

    // Next fetch address; priority is branch > accepted halt > stall > advance.
    // A stall re-reads the same word so the ROM output stays stable for decode
    // without a skid buffer.
    always_comb begin
        next_addr = fpc_q;
        if (!in_run) begin
            if (start) begin
                next_addr = start_addr;
            end
        end else if (branch_en) begin
            next_addr = branch_addr;
        end else if (retire_halt) begin
            next_addr = fpc_q;
        end else if (fbus.stall && fvalid_q) begin
            next_addr = fpc_q;
        end else begin
            next_addr = fpc_q + ADDR_W'(1);
        end
    end

    // Sequencer FSM plus the issued-address tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH_IDLE;
            fpc_q    <= '0;
            fvalid_q <= 1'b0;
        end else begin
            fpc_q <= next_addr;
            case (state_q)
                FETCH_IDLE: begin
                    if (start) begin
                        state_q  <= FETCH_RUN;
                        fvalid_q <= 1'b1;
                    end
                end
                FETCH_RUN: begin
                    // start is ignored while running
                    if (retire_halt) begin
                        state_q  <= FETCH_IDLE;
                        fvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= FETCH_IDLE;
                    fvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Retired-instruction counter: cleared by a launching start, bumped on
    // every accepted word (including the HALT that ends the run).
    xprog_fetch_sat_cnt #(
        .W (CNT_W)
    ) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (launch),
        .inc_i (accept),
        .cnt_o (retired_cnt)
    );

    assign fbus.rom_addr    = next_addr;
    assign fbus.instr       = fbus.rom_instr;
    assign fbus.instr_pc    = fpc_q;
    assign fbus.instr_valid = valid_w;
    assign busy             = in_run;

endmodule

// File: tb/tb_xprog_fetch.sv
// Bench for xprog_fetch: ROM model, a transaction-level expectation model
// checked on every falling edge, and directed stimulus with literal checks.
module tb_xprog_fetch;

    localparam int AW = 8;
    localparam int IW = 16;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic          branch_en;
    logic [AW-1:0] branch_addr;
    logic          busy;
    logic [CW-1:0] retired_cnt;

    int errors;
    int checks;

    xprog_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    xprog_fetch #(
        .ADDR_W  (AW),
        .INSTR_W (IW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .busy        (busy),
        .retired_cnt (retired_cnt),
        .fbus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: distinct word per address.
    function automatic logic [IW-1:0] rom_word(input logic [AW-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    initial bus.rom_instr = '0;
    always @(posedge clk) bus.rom_instr <= rom_word(bus.rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation model: m_run = sequencer running, m_pc = address whose
    // word decode sees, m_cnt = words decode has taken since start.
    logic          m_run;
    logic [AW-1:0] m_pc;
    logic [CW-1:0] m_cnt;

    function automatic logic m_valid();
        return m_run && !branch_en;
    endfunction

    function automatic logic m_taken();
        return m_valid() && !bus.stall;
    endfunction

    // Which word decode should see next cycle.
    function automatic logic [AW-1:0] m_next();
        if (!m_run)        return start ? start_addr : m_pc;
        if (branch_en)     return branch_addr;
        if (!m_taken())    return m_pc;           // stalled: same word again
        if (bus.halt)      return m_pc;           // HALT taken: stop advancing
        return m_pc + 8'd1;                       // 8-bit wrap
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_pc  <= '0;
            m_cnt <= '0;
        end else begin
            m_pc <= m_next();
            if (!m_run && start) begin
                m_run <= 1'b1;
                m_cnt <= '0;
            end else if (m_taken()) begin
                if (m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + 16'd1;
                if (bus.halt) m_run <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_busy", {31'd0, busy}, {31'd0, m_run});
        chk("m_valid", {31'd0, bus.instr_valid}, {31'd0, m_valid()});
        chk("m_rom_addr", {24'd0, bus.rom_addr}, {24'd0, m_next()});
        chk("m_instr_pc", {24'd0, bus.instr_pc}, {24'd0, m_pc});
        chk("m_cnt", {16'd0, retired_cnt}, {16'd0, m_cnt});
        if (m_valid()) chk("m_instr", {16'd0, bus.instr}, {16'd0, rom_word(m_pc)});
        $display("cyc t=%0t run=%0b pc=%02h valid=%0b rom_addr=%02h cnt=%0d stall=%0b halt=%0b br=%0b",
                 $time, busy, bus.instr_pc, bus.instr_valid, bus.rom_addr, retired_cnt,
                 bus.stall, bus.halt, branch_en);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Literal check of the decode view in the current cycle.
    task automatic lit(input string name, input logic v, input logic [AW-1:0] pc,
                       input logic b, input logic [CW-1:0] cnt);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
        chk({name, "_pc"}, {24'd0, bus.instr_pc}, {24'd0, pc});
        chk({name, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({name, "_cnt"}, {16'd0, retired_cnt}, {16'd0, cnt});
        if (v) chk({name, "_instr"}, {16'd0, bus.instr}, {16'd0, rom_word(pc)});
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        start_addr  = '0;
        branch_en   = 1'b0;
        branch_addr = '0;
        bus.halt    = 1'b0;
        bus.stall   = 1'b0;

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
        chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();
        lit("idle", 1'b0, 8'h00, 1'b0, 16'd0);

        // Start at 0x10.
        tick();
        start = 1'b1; start_addr = 8'h10;
        @(negedge clk);
        chk("start_rom_addr", {24'd0, bus.rom_addr}, 32'h10);
        tick();
        start = 1'b0;
        lit("run0", 1'b1, 8'h10, 1'b1, 16'd0);
        tick();
        lit("run1", 1'b1, 8'h11, 1'b1, 16'd1);

        // Stall three cycles on 0x12.
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.stall = 1'b1;
            lit("stall", 1'b1, 8'h12, 1'b1, 16'd2);
            chk("stall_rom_addr", {24'd0, bus.rom_addr}, 32'h12);
        end
        tick();
        bus.stall = 1'b0;
        lit("release", 1'b1, 8'h12, 1'b1, 16'd2);
        tick();
        lit("after_stall", 1'b1, 8'h13, 1'b1, 16'd3);

        // Branch to 0x40 while 0x14 is presented.
        tick();
        branch_en = 1'b1; branch_addr = 8'h40;
        lit("br_squash", 1'b0, 8'h14, 1'b1, 16'd4);
        // Branch together with halt: branch wins.
        tick();
        branch_en = 1'b1; branch_addr = 8'h41; bus.halt = 1'b1;
        lit("br_halt", 1'b0, 8'h40, 1'b1, 16'd4);
        tick();
        branch_en = 1'b0; bus.halt = 1'b0;
        lit("br_target", 1'b1, 8'h41, 1'b1, 16'd4);

        // Stalled HALT at 0x42, then accepted; start during RUN ignored.
        tick();
        bus.halt = 1'b1; bus.stall = 1'b1;
        lit("halt_st0", 1'b1, 8'h42, 1'b1, 16'd5);
        tick();
        start = 1'b1; start_addr = 8'h80;
        lit("halt_st1", 1'b1, 8'h42, 1'b1, 16'd5);
        tick();
        start = 1'b0; bus.stall = 1'b0;
        lit("halt_acc", 1'b1, 8'h42, 1'b1, 16'd5);
        tick();
        bus.halt = 1'b0;
        lit("halted", 1'b0, 8'h42, 1'b0, 16'd6);
        chk("halted_rom_addr", {24'd0, bus.rom_addr}, 32'h42);
        tick();
        lit("halted2", 1'b0, 8'h42, 1'b0, 16'd6);

        // Wrap-around from 0xFE.
        tick();
        start = 1'b1; start_addr = 8'hFE;
        @(negedge clk);
        tick();
        start = 1'b0;
        lit("wrap0", 1'b1, 8'hFE, 1'b1, 16'd0);
        tick();
        lit("wrap1", 1'b1, 8'hFF, 1'b1, 16'd1);
        tick();
        lit("wrap2", 1'b1, 8'h00, 1'b1, 16'd2);
        tick();
        lit("wrap3", 1'b1, 8'h01, 1'b1, 16'd3);

        // Back-to-back branches: only the last target becomes valid.
        tick();
        branch_en = 1'b1; branch_addr = 8'h30;
        lit("bb0", 1'b0, 8'h02, 1'b1, 16'd4);
        tick();
        branch_addr = 8'h50;
        lit("bb1", 1'b0, 8'h30, 1'b1, 16'd4);
        tick();
        branch_en = 1'b0;
        lit("bb2", 1'b1, 8'h50, 1'b1, 16'd4);
        tick();

        // Asynchronous reset mid-run, away from a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("arst_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
        chk("arst_pc", {24'd0, bus.instr_pc}, 32'd0);
        chk("arst_cnt", {16'd0, retired_cnt}, 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        lit("post_rst0", 1'b0, 8'h00, 1'b0, 16'd0);
        tick();
        lit("post_rst1", 1'b0, 8'h00, 1'b0, 16'd0);

        // Restart after reset.
        tick();
        start = 1'b1; start_addr = 8'h20;
        @(negedge clk);
        tick();
        start = 1'b0;
        lit("restart0", 1'b1, 8'h20, 1'b1, 16'd0);
        tick();
        lit("restart1", 1'b1, 8'h21, 1'b1, 16'd1);
        tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xprog_fetch.md
Name: xprog_fetch

Overview:
- Instruction-fetch sequencer for the synchronous program ROM, which has 1-cycle read latency and is always enabled.
- Owns the program counter and drives the ROM address every cycle.
- Tracks which address the ROM output belongs to and presents a valid, flushed instruction stream to decode.
- Handles start/halt, decode stalls, execute-stage branches, and counts retired instructions for debug.

Parameters:
- ADDR_W, `PROG_ROM_ADDR_W, ROM address width.
- INSTR_W, `INSTR_W, instruction width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin fetching at start_addr (ignored while busy)
- start_addr  in  ADDR_W  first fetch address
- halt  in  1  decode: presented instruction is a HALT
- stall  in  1  decode cannot accept the presented instruction
- branch_en  in  1  execute: redirect fetch; the presented instruction is wrong-path
- branch_addr  in  ADDR_W  branch target
- rom_addr  out  ADDR_W  ROM read address (combinational from state and inputs)
- rom_instr  in  INSTR_W  ROM registered output, data for the address issued last cycle
- instr  out  INSTR_W  equals rom_instr
- instr_pc  out  ADDR_W  address of instr (register fpc)
- instr_valid  out  1  instr is valid for decode
- busy  out  1  state is RUN
- retired_cnt  out  CNT_W  instructions accepted since last start

Behaviour:
- Registers:
  - state: IDLE or RUN.
  - fpc: address issued last cycle.
  - fvalid: last issue was a real fetch.
  - retired_cnt.
- Reset (asynchronous, any time, including mid-run):
  - state=IDLE, fpc=0, fvalid=0, retired_cnt=0.
  - Outputs immediately become instr_valid=0, busy=0, rom_addr=0, instr_pc=0.
- instr_valid = (state==RUN) & fvalid & ~branch_en. This is combinational on branch_en, which is the squash.
- accept = instr_valid & ~stall.
- Next address N, first match wins:
  - IDLE & start -> start_addr.
  - IDLE -> fpc.
  - RUN & branch_en -> branch_addr.
  - RUN & accept & halt -> fpc (hold).
  - RUN & stall & fvalid -> fpc. This re-reads the same word so instr stays stable; no skid buffer is needed.
  - RUN -> fpc+1, wrapping modulo 2^ADDR_W. Address 2^ADDR_W-1 is followed by 0, with no error.
- rom_addr = N. On each clock edge: fpc <= N.
- State transitions:
  - IDLE -> RUN on start. On that edge fvalid<=1 and retired_cnt<=0, so the first valid instruction appears 1 cycle after start.
  - RUN -> IDLE when accept & halt & ~branch_en. fvalid<=0. The HALT itself counts as retired.
  - start while RUN: ignored.
- Priority when inputs coincide: branch_en > halt > stall.
  - A branch squashes a presented HALT.
  - A branch during a stall still redirects.
  - halt without accept (stalled) has no effect until accepted.
- Branch timing:
  - Cycle t: branch_en=1, instr_valid=0.
  - Cycle t+1: instr=mem[branch_addr], instr_pc=branch_addr, valid unless a further branch arrives.
  - Back-to-back branches: each redirects; only the last target's word becomes valid.
- retired_cnt: +1 on every accept; saturates at 2^CNT_W-1; cleared only by reset or start.
- In RUN, fvalid remains 1. Stall never inserts a bubble on release: the cycle after stall drops presents fpc+1.

Decomposition:
- Shared definitions header: state encodings (FETCH_IDLE=1'b0, FETCH_RUN=1'b1). ROM latency is fixed at 1; do not make it a parameter.
- Widths come from existing xdefs/xprogdefs macros.
- No sub-module needed. Optionally a saturating counter, xsat_cnt, if reused elsewhere.

Test Plan:
- Reset, start pulse with start_addr=0x10, no stall -> instr_valid rises 1 cycle later; instr_pc sequence 0x10, 0x11, 0x12…; instr matches ROM contents; retired_cnt increments each cycle.
- Stall high 3 cycles while instr_pc=0x12 -> instr_pc=0x12 and instr held 3 cycles; rom_addr=0x12 during stall; 0x13 presented the cycle after release; retired_cnt counts 0x12 once.
- branch_en with branch_addr=0x40 while instr_pc=0x14 -> instr_valid=0 that cycle; next cycle instr_pc=0x40, valid; 0x14 not counted. Repeat with branch_en and halt together -> branch wins, busy stays 1.
- halt presented at instr_pc=0x42 with stall=1 for 2 cycles, then 0 -> still RUN while stalled; IDLE the cycle after acceptance; instr_valid=0, busy=0, rom_addr holds 0x42; a later start while RUN is ignored.
- start_addr=2^ADDR_W-2, run 4 cycles -> instr_pc 0x..FE, 0x..FF, 0x00, 0x01; no glitch in instr_valid.
- Assert rst_n low mid-RUN, not at a clock edge -> outputs clear immediately; after release, IDLE with retired_cnt=0 until next start.
